// File: rtl/mem_req_master.sv
// mem_req_master: burst initiator for a single-port synchronous memory.
// Takes read/write burst commands from a host, streams write beats into the
// memory one strobe per beat, and returns read data as a response stream
// with a fixed two-cycle latency from strobe to response.
module mem_req_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdat_valid,
  output logic                  wdat_ready,
  input  logic [DATA_WIDTH-1:0] wdat,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  done,
  output logic                  rd_wr_valid,
  output logic                  rd_wr_mem,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR       = 2'd1;
  localparam logic [1:0] S_RD       = 2'd2;
  localparam logic [1:0] S_RD_DRAIN = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_curAddr;
  logic [LEN_WIDTH-1:0]  r_beatsLeft;

  logic                  r_rdWrValid;
  logic                  r_rdWrMem;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [DATA_WIDTH-1:0] r_wrData;
  logic                  r_strobeLast;

  logic                  r_p1Valid;
  logic                  r_p1Last;
  logic                  r_p2Valid;
  logic                  r_p2Last;
  logic [DATA_WIDTH-1:0] r_rspData;
  logic                  r_done;

  logic w_cmdFire;
  logic w_wdatFire;
  logic w_lastBeat;
  logic w_rdIssue;

  assign cmd_ready  = (r_state == S_IDLE);
  assign wdat_ready = (r_state == S_WR);
  assign w_cmdFire  = cmd_valid & cmd_ready;
  assign w_wdatFire = wdat_valid & wdat_ready;
  assign w_rdIssue  = (r_state == S_RD);
  assign w_lastBeat = (r_beatsLeft == '0);

  assign rd_wr_valid = r_rdWrValid;
  assign rd_wr_mem   = r_rdWrMem;
  assign mem_addr    = r_memAddr;
  assign wr_data     = r_wrData;
  assign rsp_valid   = r_p2Valid;
  assign rsp_last    = r_p2Last;
  assign rsp_data    = r_rspData;
  assign done        = r_done;

  // Burst sequencing: state, running address and remaining beat count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_curAddr   <= '0;
      r_beatsLeft <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmdFire) begin
            r_curAddr   <= cmd_addr;
            r_beatsLeft <= cmd_len;
            r_state     <= cmd_write ? S_WR : S_RD;
          end
        end
        S_WR: begin
          if (w_wdatFire) begin
            r_curAddr   <= r_curAddr + 1'b1;
            r_beatsLeft <= r_beatsLeft - 1'b1;
            if (w_lastBeat) r_state <= S_IDLE;
          end
        end
        S_RD: begin
          r_curAddr   <= r_curAddr + 1'b1;
          r_beatsLeft <= r_beatsLeft - 1'b1;
          if (w_lastBeat) r_state <= S_RD_DRAIN;
        end
        S_RD_DRAIN: begin
          if (r_p2Valid && r_p2Last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory strobe: one registered access per write handshake or read issue;
  // address/data/direction hold their last values between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdWrValid  <= 1'b0;
      r_rdWrMem    <= 1'b0;
      r_memAddr    <= '0;
      r_wrData     <= '0;
      r_strobeLast <= 1'b0;
    end else begin
      r_rdWrValid  <= 1'b0;
      r_strobeLast <= 1'b0;
      if (w_wdatFire) begin
        r_rdWrValid  <= 1'b1;
        r_rdWrMem    <= 1'b1;
        r_memAddr    <= r_curAddr;
        r_wrData     <= wdat;
        r_strobeLast <= w_lastBeat;
      end else if (w_rdIssue) begin
        r_rdWrValid  <= 1'b1;
        r_rdWrMem    <= 1'b0;
        r_memAddr    <= r_curAddr;
        r_strobeLast <= w_lastBeat;
      end
    end
  end

  // Read response pipeline: stage 1 marks the cycle the memory presents
  // rd_data, stage 2 carries the captured beat out; done is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1Valid <= 1'b0;
      r_p1Last  <= 1'b0;
      r_p2Valid <= 1'b0;
      r_p2Last  <= 1'b0;
      r_rspData <= '0;
      r_done    <= 1'b0;
    end else begin
      r_p1Valid <= r_rdWrValid & ~r_rdWrMem;
      r_p1Last  <= r_rdWrValid & ~r_rdWrMem & r_strobeLast;
      r_p2Valid <= r_p1Valid;
      r_p2Last  <= r_p1Last;
      if (r_p1Valid) r_rspData <= rd_data;
      r_done    <= (w_wdatFire & w_lastBeat) | (r_p1Valid & r_p1Last);
    end
  end

endmodule

// File: tb/tb_mem_req_master.sv
// tb_mem_req_master: vector table of burst commands plus hand-written
// sequences for address gaps, mid-burst reset and command back-pressure.
// A simple memory model answers the strobes; expected strobes and responses
// are queued when commands are issued and consumed by a negedge monitor.
module tb_mem_req_master;

  typedef struct {
    bit          write;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [31:0] base;
    int          gapBeat;
    int          gapLen;
  } cmdVec_t;

  typedef struct {
    bit          write;
    logic [15:0] addr;
    logic [31:0] data;
    bit          last;
  } strobe_t;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wdat_valid = 1'b0;
  logic        wdat_ready;
  logic [31:0] wdat = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        done;
  logic        rd_wr_valid;
  logic        rd_wr_mem;
  logic [15:0] mem_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data = '0;

  logic [31:0] memArr [0:65535];
  logic [31:0] shadow [0:65535];

  strobe_t strobeQ[$];
  rsp_t    rspQ[$];
  int      rspCycleQ[$];
  int      wrCycleQ[$];

  int nChecks = 0;
  int nFail = 0;
  int cycle = 0;
  int doneCount = 0;
  int rdStrobes = 0;
  int lastRspCycle = -1;
  bit pendReadyCheck = 0;

  cmdVec_t vecs[8];

  mem_req_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .done(done),
    .rd_wr_valid(rd_wr_valid), .rd_wr_mem(rd_wr_mem), .mem_addr(mem_addr),
    .wr_data(wr_data), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time strobes and responses.
  always @(posedge clk) cycle++;

  // Memory model: writes land on the strobe edge, reads are registered then.
  always @(posedge clk) begin
    if (rd_wr_valid) begin
      if (rd_wr_mem) memArr[mem_addr] <= wr_data;
      else rd_data <= memArr[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic timeoutFail(input string name);
    nChecks++;
    nFail++;
    $display("[TB] FAIL %s: timed out at cycle %0d", name, cycle);
  endtask

  // Monitor: consumes expected strobes/responses and checks done/cmd_ready.
  always @(negedge clk) begin
    if (!rst) begin
      strobe_t s;
      rsp_t    r;
      bit      expDone;
      int      expCyc;
      expDone = 0;
      if (pendReadyCheck) begin
        checkOutput("ready_after_rsp_last", 32'(cmd_ready), 32'd1);
        pendReadyCheck = 0;
      end
      if (rd_wr_valid) begin
        if (strobeQ.size() == 0) begin
          timeoutFail("unexpected_strobe");
        end else begin
          s = strobeQ.pop_front();
          checkOutput("strobe_dir", 32'(rd_wr_mem), 32'(s.write));
          checkOutput("strobe_addr", 32'(mem_addr), 32'(s.addr));
          if (s.write) begin
            checkOutput("strobe_wdata", wr_data, s.data);
            wrCycleQ.push_back(cycle);
            if (s.last) begin
              expDone = 1;
              checkOutput("ready_on_wr_done", 32'(cmd_ready), 32'd1);
            end
          end else begin
            rspCycleQ.push_back(cycle + 2);
            rdStrobes++;
            checkOutput("ready_during_read", 32'(cmd_ready), 32'd0);
          end
        end
      end
      if (rsp_valid) begin
        if (rspQ.size() == 0 || rspCycleQ.size() == 0) begin
          timeoutFail("unexpected_rsp");
        end else begin
          r = rspQ.pop_front();
          expCyc = rspCycleQ.pop_front();
          checkOutput("rsp_data", rsp_data, r.data);
          checkOutput("rsp_last", 32'(rsp_last), 32'(r.last));
          checkOutput("rsp_latency", cycle, expCyc);
          if (r.last) begin
            expDone = 1;
            lastRspCycle = cycle;
            pendReadyCheck = 1;
            checkOutput("ready_on_rsp_last", 32'(cmd_ready), 32'd0);
          end
        end
      end
      if (done || expDone) checkOutput("done", 32'(done), 32'(expDone));
      if (done) doneCount++;
    end
  end

  // Queue expected strobes (and read responses) for an accepted command.
  task automatic pushExpect(input cmdVec_t v);
    for (int i = 0; i <= int'(v.len); i++) begin
      strobe_t s;
      rsp_t    r;
      s.write = v.write;
      s.addr  = v.addr + 16'(i);
      s.last  = (i == int'(v.len));
      s.data  = v.base + 32'(i);
      if (v.write) begin
        shadow[s.addr] = s.data;
      end else begin
        r.data = shadow[s.addr];
        r.last = s.last;
        rspQ.push_back(r);
      end
      strobeQ.push_back(s);
    end
  endtask

  task automatic sendCmd(input cmdVec_t v, output int accCycle);
    int waited;
    waited = 0;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_len   = v.len;
    while (!cmd_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_ready) begin
      timeoutFail("cmd_accept");
      cmd_valid = 1'b0;
      accCycle = -1;
    end else begin
      accCycle = cycle;
      pushExpect(v);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic sendWdat(input cmdVec_t v);
    for (int i = 0; i <= int'(v.len); i++) begin
      int waited;
      if (i == v.gapBeat) begin
        wdat_valid = 1'b0;
        repeat (v.gapLen) @(posedge clk);
        #1;
      end
      wdat_valid = 1'b1;
      wdat = v.base + 32'(i);
      waited = 0;
      while (!wdat_ready && waited < 200) begin
        @(posedge clk); #1;
        waited++;
      end
      if (!wdat_ready) begin
        timeoutFail("wdat_accept");
        break;
      end
      @(posedge clk); #1;
    end
    wdat_valid = 1'b0;
  endtask

  task automatic waitDone(input int startCount);
    int waited;
    waited = 0;
    while (doneCount == startCount && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (doneCount == startCount) timeoutFail("wait_done");
  endtask

  task automatic applyStimulus(input cmdVec_t v);
    int acc;
    int startDone;
    startDone = doneCount;
    sendCmd(v, acc);
    if (acc >= 0) begin
      if (v.write) sendWdat(v);
      waitDone(startDone);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout at cycle %0d", cycle);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int acc;
    int base;
    int startDone;
    cmdVec_t v;

    vecs[0] = '{1'b1, 16'h0010, 8'd0,  32'hDEADBEEF, -1, 0};
    vecs[1] = '{1'b0, 16'h0010, 8'd0,  32'h0,        -1, 0};
    vecs[2] = '{1'b1, 16'h0100, 8'd3,  32'h000000A0,  2, 2};
    vecs[3] = '{1'b0, 16'h0100, 8'd3,  32'h0,        -1, 0};
    vecs[4] = '{1'b1, 16'hFFFF, 8'd1,  32'h12345678, -1, 0};
    vecs[5] = '{1'b0, 16'hFFFF, 8'd1,  32'h0,        -1, 0};
    vecs[6] = '{1'b1, 16'h2000, 8'd15, 32'h55AA0000, -1, 0};
    vecs[7] = '{1'b0, 16'h2000, 8'd15, 32'h0,        -1, 0};

    #1;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_rd_wr_valid", 32'(rd_wr_valid), 32'd0);
    checkOutput("reset_wdat_ready", 32'(wdat_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      if (i == 2) wrCycleQ.delete();
      applyStimulus(vecs[i]);
      if (i == 2) begin
        checkOutput("gap_wr_strobe_count", 32'(wrCycleQ.size()), 32'd4);
        if (wrCycleQ.size() == 4) begin
          checkOutput("gap_beat0_to_1", 32'(wrCycleQ[1] - wrCycleQ[0]), 32'd1);
          checkOutput("gap_beat1_to_2", 32'(wrCycleQ[2] - wrCycleQ[1]), 32'd3);
          checkOutput("gap_beat2_to_3", 32'(wrCycleQ[3] - wrCycleQ[2]), 32'd1);
        end
      end
    end

    $display("[TB] mid-burst reset sequence");
    v = '{1'b0, 16'h0100, 8'd7, 32'h0, -1, 0};
    base = rdStrobes;
    sendCmd(v, acc);
    for (int w = 0; w < 50 && rdStrobes < base + 2; w++) begin
      @(negedge clk); #1;
    end
    if (rdStrobes < base + 2) timeoutFail("reset_wait_strobes");
    rst = 1'b1;
    #1;
    checkOutput("reset_strobe_drop", 32'(rd_wr_valid), 32'd0);
    strobeQ.delete();
    rspQ.delete();
    rspCycleQ.delete();
    pendReadyCheck = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    startDone = doneCount;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("no_done_after_abort", 32'(doneCount - startDone), 32'd0);
    applyStimulus(vecs[1]);

    $display("[TB] command held during read drain");
    startDone = doneCount;
    sendCmd(vecs[3], acc);
    v = '{1'b1, 16'h0300, 8'd2, 32'hC0DE0000, -1, 0};
    sendCmd(v, acc);
    checkOutput("held_cmd_accept_cycle", 32'(acc), 32'(lastRspCycle + 1));
    if (acc >= 0) begin
      sendWdat(v);
      waitDone(startDone + 1);
    end
    applyStimulus('{1'b0, 16'h0300, 8'd2, 32'h0, -1, 0});

    repeat (5) @(posedge clk);
    #1;
    checkOutput("strobe_queue_empty", 32'(strobeQ.size()), 32'd0);
    checkOutput("rsp_queue_empty", 32'(rspQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
